// File: rtl/axis_frame_checker.sv
// AXI-Stream frame checker: generates tready in one of four patterns and checks SOF/EOL framing of accepted beats.
// Optional perf counters (stall_cnt, beat_cnt) exist only when AXIS_CHK_PERF_EN is defined; otherwise they read 0.
module axis_frame_checker #(
  parameter int X_SIZE       = 480,
  parameter int Y_SIZE       = 640,
  parameter int TIMEOUT      = 1000,
  parameter int RND_SEED     = 1246504138,
  parameter int READY_ON     = 3,
  parameter int READY_PERIOD = 8,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [1:0]                mode,
  input  logic                      s_valid,
  input  logic                      s_sof,
  input  logic                      s_eol,
  output logic                      s_ready,
  output logic [$clog2(X_SIZE)-1:0] x_cnt,
  output logic [$clog2(Y_SIZE)-1:0] y_cnt,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic [CNT_W-1:0]          sof_err_cnt,
  output logic [CNT_W-1:0]          eol_err_cnt,
  output logic [CNT_W-1:0]          tmo_cnt,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          beat_cnt,
  output logic                      frame_done,
  output logic                      err_any
);

  localparam int XW = $clog2(X_SIZE);
  localparam int YW = $clog2(Y_SIZE);
  localparam int PW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [XW-1:0]    X_LAST  = XW'(X_SIZE - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(Y_SIZE - 1);
  localparam logic [PW-1:0]    P_LAST  = PW'(READY_PERIOD - 1);
  localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

  state_t          state;
  logic [32:0]     prbs;
  logic [PW-1:0]   phase;
  logic [TW-1:0]   timer;
  logic            accept, at_origin, restart, take;
  logic            sof_err, eol_err, tmo_hit, frame_end;
  logic            at_last, line_end;
  logic [XW-1:0]   bx;
  logic [YW-1:0]   by;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready <= 1'b0;
      prbs    <= 33'(RND_SEED);
      phase   <= '0;
    end else begin
      prbs  <= {prbs[31:0], prbs[32] ^ ~prbs[19]};
      phase <= (phase == P_LAST) ? '0 : phase + PW'(1);
      case (mode)
        2'd0:    s_ready <= 1'b1;
        2'd1:    s_ready <= prbs[32];
        2'd2:    s_ready <= s_valid & ~s_ready;
        default: s_ready <= (int'(phase) < READY_ON);
      endcase
    end
  end

  // A restarting SOF beat is evaluated as if it sat at x=0,y=0.
  always_comb begin
    accept    = s_valid & s_ready;
    at_origin = (x_cnt == '0) && (y_cnt == '0);
    restart   = accept & s_sof & ((state == WAIT_SOF) | ~at_origin);
    sof_err   = accept & (((state == WAIT_SOF) & ~s_sof) |
                          ((state == IN_FRAME) & s_sof & ~at_origin));
    take      = accept & ((state == IN_FRAME) | s_sof);
    bx        = restart ? '0 : x_cnt;
    by        = restart ? '0 : y_cnt;
    at_last   = (bx == X_LAST);
    line_end  = at_last | s_eol;
    eol_err   = take & (at_last ^ s_eol);
    frame_end = take & line_end & (by == Y_LAST);
    tmo_hit   = ~s_valid & (timer == T_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_SOF;
      x_cnt      <= '0;
      y_cnt      <= '0;
      frame_done <= 1'b0;
      timer      <= '0;
    end else begin
      frame_done <= frame_end;
      timer      <= (s_valid || tmo_hit) ? '0 : timer + TW'(1);
      if (take) begin
        state <= frame_end ? WAIT_SOF : IN_FRAME;
        if (line_end) begin
          x_cnt <= '0;
          y_cnt <= (by == Y_LAST) ? '0 : by + YW'(1);
        end else begin
          x_cnt <= bx + XW'(1);
          y_cnt <= by;
        end
      end
    end
  end

  // clear takes priority over any increment landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      frame_cnt   <= '0;
      sof_err_cnt <= '0;
      eol_err_cnt <= '0;
      tmo_cnt     <= '0;
      err_any     <= 1'b0;
    end else begin
      frame_cnt   <= sat_inc(frame_cnt, restart);
      sof_err_cnt <= sat_inc(sof_err_cnt, sof_err);
      eol_err_cnt <= sat_inc(eol_err_cnt, eol_err);
      tmo_cnt     <= sat_inc(tmo_cnt, tmo_hit);
      if (sof_err || eol_err || tmo_hit)
        err_any <= 1'b1;
    end
  end

`ifdef AXIS_CHK_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stall_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, s_valid & ~s_ready);
      beat_cnt  <= sat_inc(beat_cnt, accept);
    end
  end
`else
  assign stall_cnt = '0;
  assign beat_cnt  = '0;
`endif

endmodule

// File: tb/tb_axis_frame_checker.sv
// Randomized bench for axis_frame_checker: a beat-position reference model is compared on every cycle,
// plus directed scenarios with hand-computed expected values.
module tb_axis_frame_checker;
  localparam int XS   = 4;
  localparam int YS   = 2;
  localparam int TMO  = 10;
  localparam int CW   = 8;
  localparam int CMAX = 255;
  localparam int SEED = 1246504138;
  localparam int R_ON = 3;
  localparam int R_PER = 8;

  logic          clk = 1'b0;
  logic          rst, clear, s_valid, s_sof, s_eol, s_ready;
  logic [1:0]    mode;
  logic [1:0]    x_cnt;
  logic [0:0]    y_cnt;
  logic [CW-1:0] frame_cnt, sof_err_cnt, eol_err_cnt, tmo_cnt, stall_cnt, beat_cnt;
  logic          frame_done, err_any;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  axis_frame_checker #(
    .X_SIZE(XS), .Y_SIZE(YS), .TIMEOUT(TMO), .RND_SEED(SEED),
    .READY_ON(R_ON), .READY_PERIOD(R_PER), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .s_valid(s_valid), .s_sof(s_sof), .s_eol(s_eol), .s_ready(s_ready),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_cnt(frame_cnt), .sof_err_cnt(sof_err_cnt),
    .eol_err_cnt(eol_err_cnt), .tmo_cnt(tmo_cnt), .stall_cnt(stall_cnt), .beat_cnt(beat_cnt),
    .frame_done(frame_done), .err_any(err_any)
  );

  always #5 clk = ~clk;

  function void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int sat(input int v, input bit en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction

  // Reference model: frame position kept as a linear beat index within the frame.
  bit          m_started = 0;
  bit          m_ready, m_in, m_done, m_err;
  int          m_pos, m_frame, m_sof, m_eol, m_tmo, m_stall, m_beat, m_phase, m_idle;
  logic [32:0] m_prbs;

  always @(posedge clk) begin : model
    bit acc, nr, nd, e_sof, e_eol, e_tmo, e_frm;
    int col, row;
    if (rst) begin
      m_started = 1;
      m_ready = 0; m_in = 0; m_pos = 0; m_done = 0; m_err = 0;
      m_frame = 0; m_sof = 0; m_eol = 0; m_tmo = 0; m_stall = 0; m_beat = 0;
      m_prbs = 33'(SEED); m_phase = 0; m_idle = 0;
    end else begin
      acc = s_valid && m_ready;
      case (mode)
        2'd0:    nr = 1;
        2'd1:    nr = m_prbs[32];
        2'd2:    nr = s_valid && !m_ready;
        default: nr = (m_phase < R_ON);
      endcase
      m_prbs  = {m_prbs[31:0], m_prbs[32] ^ ~m_prbs[19]};
      m_phase = (m_phase + 1) % R_PER;
      nd = 0; e_sof = 0; e_eol = 0; e_tmo = 0; e_frm = 0;
      if (acc) begin
        if (!m_in && !s_sof) begin
          e_sof = 1;
        end else begin
          if (s_sof && (!m_in || m_pos != 0)) begin
            e_sof = m_in;
            e_frm = 1;
            m_pos = 0;
            m_in  = 1;
          end
          col = m_pos % XS;
          row = m_pos / XS;
          if ((col == XS - 1) != s_eol) e_eol = 1;
          m_pos = (col == XS - 1 || s_eol) ? (row + 1) * XS : m_pos + 1;
          if (m_pos >= XS * YS) begin
            m_pos = 0; m_in = 0; nd = 1;
          end
        end
      end
      if (s_valid) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TMO) begin e_tmo = 1; m_idle = 0; end
      end
      if (clear) begin
        m_frame = 0; m_sof = 0; m_eol = 0; m_tmo = 0; m_stall = 0; m_beat = 0; m_err = 0;
      end else begin
        m_frame = sat(m_frame, e_frm);
        m_sof   = sat(m_sof, e_sof);
        m_eol   = sat(m_eol, e_eol);
        m_tmo   = sat(m_tmo, e_tmo);
`ifdef AXIS_CHK_PERF_EN
        m_stall = sat(m_stall, s_valid && !m_ready);
        m_beat  = sat(m_beat, acc);
`endif
        if (e_sof || e_eol || e_tmo) m_err = 1;
      end
      m_ready = nr;
      m_done  = nd;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("s_ready",     int'(s_ready),     int'(m_ready));
      chk("x_cnt",       int'(x_cnt),       m_pos % XS);
      chk("y_cnt",       int'(y_cnt),       m_pos / XS);
      chk("frame_cnt",   int'(frame_cnt),   m_frame);
      chk("sof_err_cnt", int'(sof_err_cnt), m_sof);
      chk("eol_err_cnt", int'(eol_err_cnt), m_eol);
      chk("tmo_cnt",     int'(tmo_cnt),     m_tmo);
      chk("stall_cnt",   int'(stall_cnt),   m_stall);
      chk("beat_cnt",    int'(beat_cnt),    m_beat);
      chk("frame_done",  int'(frame_done),  int'(m_done));
      chk("err_any",     int'(err_any),     int'(m_err));
      if (frame_done) done_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 0; s_sof = 0; s_eol = 0;
  endtask

  task automatic beat(input logic sof, input logic eol);
    s_valid = 1; s_sof = sof; s_eol = eol;
    tick();
    idle();
  endtask

  // Leaves mode 0 selected with s_ready already high.
  task automatic reset_seq();
    idle();
    clear = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    mode = 2'd0;
    tick(); tick();
  endtask

  initial begin
    int d0;
    rst = 1; clear = 0; mode = 2'd0;
    idle();
    tick(); tick();
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_x", int'(x_cnt), 0);
    chk("rst_y", int'(y_cnt), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_err_any", int'(err_any), 0);
    rst = 0;
    tick(); tick();

    // Two clean frames.
    d0 = done_seen;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) beat(i == 0, i == 3 || i == 7);
    tick();
    chk("clean_frame_cnt", int'(frame_cnt), 2);
    chk("clean_done_pulses", done_seen - d0, 2);
    chk("clean_sof_err", int'(sof_err_cnt), 0);
    chk("clean_eol_err", int'(eol_err_cnt), 0);
    chk("clean_tmo", int'(tmo_cnt), 0);
    chk("clean_err_any", int'(err_any), 0);

    // Early EOL on beat 2 of line 0.
    reset_seq();
    beat(1, 0); beat(0, 0); beat(0, 1);
    chk("early_eol_cnt", int'(eol_err_cnt), 1);
    chk("early_eol_y", int'(y_cnt), 1);
    chk("early_eol_x", int'(x_cnt), 0);
    chk("early_eol_err_any", int'(err_any), 1);

    // SOF reasserted on beat 5.
    reset_seq();
    for (int i = 0; i < 6; i++) beat(i == 0 || i == 5, i == 3);
    chk("resof_sof_err", int'(sof_err_cnt), 1);
    chk("resof_frame_cnt", int'(frame_cnt), 2);
    chk("resof_x", int'(x_cnt), 1);

    // Idle timeouts then clear.
    reset_seq();
    clear = 1; tick(); clear = 0;
    idle();
    for (int i = 0; i < 25; i++) tick();
    chk("tmo_cnt_25", int'(tmo_cnt), 2);
    clear = 1; tick(); clear = 0;
    chk("tmo_after_clear", int'(tmo_cnt), 0);
    chk("err_after_clear", int'(err_any), 0);

    // PRBS ready for 200 cycles with s_valid held high.
    reset_seq();
    mode = 2'd1; s_valid = 1; clear = 1;
    tick();
    clear = 0;
    for (int i = 0; i < 200; i++) tick();
`ifdef AXIS_CHK_PERF_EN
    chk("stall_plus_beat", int'(stall_cnt) + int'(beat_cnt), 200);
`else
    chk("stall_plus_beat", int'(stall_cnt) + int'(beat_cnt), 0);
`endif
    idle();

    // Reset mid-frame at beat 3 of line 1.
    reset_seq();
    for (int i = 0; i < 7; i++) beat(i == 0, i == 3);
    rst = 1; tick(); tick(); rst = 0;
    tick(); tick();
    beat(0, 0);
    chk("midrst_sof_err", int'(sof_err_cnt), 1);
    chk("midrst_frame_cnt", int'(frame_cnt), 0);
    chk("midrst_x", int'(x_cnt), 0);
    beat(1, 0);
    chk("midrst_resync_frame", int'(frame_cnt), 1);
    chk("midrst_resync_x", int'(x_cnt), 1);

    // Randomized traffic across all ready modes, with clears, resets and idle bursts.
    reset_seq();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      s_valid = ($urandom_range(0, 99) < 70) && ((c % 400) < 380);
      s_sof   = ($urandom_range(0, 7) == 0);
      s_eol   = ($urandom_range(0, 3) == 0);
      clear   = ($urandom_range(0, 299) == 0);
      rst     = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 0; clear = 0;

    // Timeout counter saturation.
    reset_seq();
    idle();
    for (int i = 0; i < 2600; i++) tick();
    chk("tmo_saturated", int'(tmo_cnt), CMAX);
    chk("tmo_sat_err_any", int'(err_any), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
